// File: rtl/distributor_pkg.sv
// Shared types and helpers for the burst distributor.
// Provides the channel state enum, select-width helper and counter width.
package distributor_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  localparam int OVR_W = 8;

  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/distributor_burst_ch.sv
// One output channel: FSM, burst counter, source latch, output register.
// Ports: i_clk/i_rst, i_valid, i_start, i_sel, i_len, src_data (muxed by
// parent using sel), sel, o_data, o_valid, o_busy, o_done.
// DISTRIBUTOR_OVERRUN_CNT_EN adds i_ovr_clr and o_overrun.
module distributor_burst_ch
  import distributor_pkg::*;
#(
  parameter int DW   = 8,
  parameter int LENW = 8,
  parameter int SELW = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic            i_start,
  input  logic [SELW-1:0] i_sel,
  input  logic [LENW-1:0] i_len,
  input  logic [DW-1:0]   src_data,
  output logic [SELW-1:0] sel,
  output logic [DW-1:0]   o_data,
  output logic            o_valid,
  output logic            o_busy,
  output logic            o_done
`ifdef DISTRIBUTOR_OVERRUN_CNT_EN
  ,
  input  logic             i_ovr_clr,
  output logic [OVR_W-1:0] o_overrun
`endif
);

  state_e          state;
  state_e          state_d;
  logic [LENW-1:0] cnt;
  logic [LENW-1:0] cnt_d;
  logic [SELW-1:0] sel_d;
  logic [DW-1:0]   data_d;
  logic            valid_d;
  logic            done_d;
  logic            arm;
  logic            last;

  assign arm    = i_start && (i_len != '0);
  assign last   = i_valid && (cnt == LENW'(1));
  assign o_busy = (state == RUN);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sel     <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      sel     <= sel_d;
      o_data  <= data_d;
      o_valid <= valid_d;
      o_done  <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sel_d   = sel;
    data_d  = o_data;
    valid_d = 1'b0;
    done_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (arm) begin
          state_d = RUN;
          sel_d   = i_sel;
          cnt_d   = i_len;
        end
      end
      RUN: begin
        if (i_valid) begin
          data_d  = src_data;
          valid_d = 1'b1;
          cnt_d   = cnt - LENW'(1);
        end
        if (last) begin
          done_d = 1'b1;
          // A start on the final sample re-arms gaplessly.
          if (arm) begin
            sel_d = i_sel;
            cnt_d = i_len;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DISTRIBUTOR_OVERRUN_CNT_EN
  logic ovr_inc;

  // Starts dropped mid-burst; the final-cycle re-arm is not a drop.
  assign ovr_inc = arm && (state == RUN) && !last;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_overrun <= '0;
    end else if (i_ovr_clr) begin
      o_overrun <= '0;
    end else if (ovr_inc && (o_overrun != '1)) begin
      o_overrun <= o_overrun + OVR_W'(1);
    end
  end
`endif

endmodule

// File: rtl/distributor_burst.sv
// N_CH-channel burst distributor: each output picks any input as source.
// Ports: i_clk, i_rst (async low), i_valid, i_data, i_start, i_sel, i_len,
// o_data, o_valid, o_busy, o_done.
// DISTRIBUTOR_OVERRUN_CNT_EN adds i_ovr_clr and o_overrun.
module distributor_burst
  import distributor_pkg::*;
#(
  parameter  int N_CH = 10,
  parameter  int DW   = 8,
  parameter  int LENW = 8,
  localparam int SELW = sel_width(N_CH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [N_CH*DW-1:0]   i_data,
  input  logic [N_CH-1:0]      i_start,
  input  logic [N_CH*SELW-1:0] i_sel,
  input  logic [LENW-1:0]      i_len,
  output logic [N_CH*DW-1:0]   o_data,
  output logic [N_CH-1:0]      o_valid,
  output logic [N_CH-1:0]      o_busy,
  output logic [N_CH-1:0]      o_done
`ifdef DISTRIBUTOR_OVERRUN_CNT_EN
  ,
  input  logic                  i_ovr_clr,
  output logic [N_CH*OVR_W-1:0] o_overrun
`endif
);

  logic [SELW-1:0] ch_sel [N_CH];
  logic [DW-1:0]   ch_src [N_CH];

  // Out-of-range selects fall through to zero.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      ch_src[k] = '0;
      for (int j = 0; j < N_CH; j++) begin
        if (ch_sel[k] == SELW'(j)) begin
          ch_src[k] = i_data[j*DW +: DW];
        end
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    distributor_burst_ch #(
      .DW   (DW),
      .LENW (LENW),
      .SELW (SELW)
    ) u_ch (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_valid   (i_valid),
      .i_start   (i_start[k]),
      .i_sel     (i_sel[k*SELW +: SELW]),
      .i_len     (i_len),
      .src_data  (ch_src[k]),
      .sel       (ch_sel[k]),
      .o_data    (o_data[k*DW +: DW]),
      .o_valid   (o_valid[k]),
      .o_busy    (o_busy[k]),
      .o_done    (o_done[k])
`ifdef DISTRIBUTOR_OVERRUN_CNT_EN
      ,
      .i_ovr_clr (i_ovr_clr),
      .o_overrun (o_overrun[k*OVR_W +: OVR_W])
`endif
    );
  end

endmodule

// File: tb/tb_distributor_burst.sv
// Scoreboard bench for distributor_burst (N_CH=10, DW=8, LENW=8).
// Exercises reset, bursts, gaps, re-arm, edge selects and abort.
module tb_distributor_burst;

  localparam int N  = 10;
  localparam int DW = 8;
  localparam int LW = 8;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic [N*DW-1:0] data;
  logic [N-1:0]  start;
  logic [N*SW-1:0] sel;
  logic [LW-1:0] len;
  logic [N*DW-1:0] o_data;
  logic [N-1:0]  o_valid;
  logic [N-1:0]  o_busy;
  logic [N-1:0]  o_done;
`ifdef DISTRIBUTOR_OVERRUN_CNT_EN
  logic          ovr_clr;
  logic [N*8-1:0] o_overrun;
`endif

  distributor_burst #(
    .N_CH (N),
    .DW   (DW),
    .LENW (LW)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_valid   (valid),
    .i_data    (data),
    .i_start   (start),
    .i_sel     (sel),
    .i_len     (len),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_busy    (o_busy),
    .o_done    (o_done)
`ifdef DISTRIBUTOR_OVERRUN_CNT_EN
    ,
    .i_ovr_clr (ovr_clr),
    .o_overrun (o_overrun)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       dn;
    int         c;
  } exp_t;

  typedef struct {
    logic [95:0]  nm;
    logic [127:0] got;
    logic [127:0] exp;
  } chk_t;

  exp_t q [N][$];
  chk_t chk_q [$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   busy_cnt [N];

  initial begin
    for (int k = 0; k < N; k++) busy_cnt[k] = 0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: drains posted checks and matches outputs to scoreboard.
  always @(negedge clk) begin
    chk_t c;
    exp_t e;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      tests++;
      if (c.got !== c.exp) begin
        fails++;
        $display("FAIL %s got %0h want %0h", c.nm, c.got, c.exp);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (o_busy[k]) busy_cnt[k]++;
      if (o_done[k] && !o_valid[k]) begin
        tests++;
        fails++;
        $display("FAIL done_no_valid ch%0d cyc %0d", k, cyc);
      end
      if (o_valid[k]) begin
        tests++;
        if (q[k].size() == 0) begin
          fails++;
          $display("FAIL sb_extra ch%0d got d=%0h done=%0b cyc %0d",
                   k, o_data[k*DW +: DW], o_done[k], cyc);
        end else begin
          e = q[k].pop_front();
          if (o_data[k*DW +: DW] !== e.d || o_done[k] !== e.dn ||
              cyc != e.c) begin
            fails++;
            $display("FAIL sb ch%0d got d=%0h dn=%0b cyc=%0d want d=%0h dn=%0b cyc=%0d",
                     k, o_data[k*DW +: DW], o_done[k], cyc, e.d, e.dn, e.c);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic post(input logic [95:0] nm, input logic [127:0] got,
                      input logic [127:0] exp);
    chk_q.push_back('{nm, got, exp});
  endtask

  task automatic push(input int ch, input logic [7:0] d, input logic dn,
                      input int c);
    q[ch].push_back('{d, dn, c});
  endtask

  task automatic rnd_data();
    data = 80'({$urandom(), $urandom(), $urandom()});
  endtask

  task automatic put(input int ch, input logic [7:0] v);
    data[ch*DW +: DW] = v;
  endtask

  task automatic set_sel(input int ch, input logic [SW-1:0] v);
    sel[ch*SW +: SW] = v;
  endtask

  function automatic logic [127:0] outs();
    return 128'({o_data, o_valid, o_busy, o_done});
  endfunction

  int b0;

  initial begin
    rst   = 1'b0;
    valid = 1'b0;
    data  = '0;
    start = '0;
    sel   = '0;
    len   = '0;
`ifdef DISTRIBUTOR_OVERRUN_CNT_EN
    ovr_clr = 1'b0;
`endif

    // Reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      step();
      valid = 1'($urandom());
      rnd_data();
      start = 10'($urandom());
      sel   = 40'({$urandom(), $urandom()});
      len   = 8'($urandom());
      post("rst_hold", outs(), '0);
    end
    start = '0;
    rst   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      valid = 1'($urandom());
      rnd_data();
    end
    post("rel_busy", 128'(o_busy), '0);

    // Basic burst ch3 <- ch7, len 4
    step();
    sel = '0;
    b0 = busy_cnt[3];
    start[3] = 1'b1;
    set_sel(3, 4'd7);
    len   = 8'd4;
    valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      start = '0;
      valid = 1'b1;
      rnd_data();
      put(7, 8'h10 + 8'(i));
      push(3, 8'h10 + 8'(i), i == 3, cyc + 1);
    end
    step();
    valid = 1'b0;
    step();
    step();
    post("busy_len4", 128'(busy_cnt[3] - b0), 128'(4));

    // Gapped valid ch2 <- ch4, len 3, pattern 1,0,1,0,1
    step();
    start[2] = 1'b1;
    set_sel(2, 4'd4);
    len   = 8'd3;
    valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      start = '0;
      valid = (i % 2 == 0);
      rnd_data();
      put(4, 8'h20 + 8'(i));
      if (valid) push(2, 8'h20 + 8'(i), i == 4, cyc + 1);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      valid = 1'b1;
      rnd_data();
    end
    post("gap_idle", 128'(o_busy[2]), '0);

    // ch0 <- ch2 len 5, ignored start, then re-arm <- ch1 len 2
    step();
    start[0] = 1'b1;
    set_sel(0, 4'd2);
    len   = 8'd5;
    valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      start = '0;
      valid = 1'b1;
      rnd_data();
      put(2, 8'h30 + 8'(i));
      if (i == 1) begin
        start[0] = 1'b1;
        set_sel(0, 4'd6);
        len = 8'd9;
      end
      if (i == 4) begin
        start[0] = 1'b1;
        set_sel(0, 4'd1);
        len = 8'd2;
      end
      push(0, 8'h30 + 8'(i), i == 4, cyc + 1);
    end
    for (int j = 0; j < 2; j++) begin
      step();
      start = '0;
      valid = 1'b1;
      rnd_data();
      put(1, 8'h40 + 8'(j));
      push(0, 8'h40 + 8'(j), j == 1, cyc + 1);
    end
    step();
    valid = 1'b0;
    post("rearm_idle", 128'(o_busy[0]), '0);
`ifdef DISTRIBUTOR_OVERRUN_CNT_EN
    post("ovr_ch0", 128'(o_overrun[7:0]), 128'(1));
    post("ovr_other", 128'(o_overrun[79:8]), '0);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    post("ovr_clr", 128'(o_overrun), '0);
`endif

    // len 0 start is ignored
    step();
    start[5] = 1'b1;
    len   = 8'd0;
    valid = 1'b1;
    step();
    start = '0;
    step();
    post("len0_busy", 128'(o_busy), '0);
`ifdef DISTRIBUTOR_OVERRUN_CNT_EN
    post("len0_ovr", 128'(o_overrun), '0);
`endif

    // Out-of-range select gives zeros
    step();
    start[6] = 1'b1;
    set_sel(6, 4'd12);
    len   = 8'd2;
    valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      start = '0;
      valid = 1'b1;
      rnd_data();
      push(6, 8'h00, i == 1, cyc + 1);
    end

    // All channels fan out from ch5
    step();
    start = '1;
    for (int k = 0; k < N; k++) set_sel(k, 4'd5);
    len   = 8'd1;
    valid = 1'b0;
    step();
    start = '0;
    valid = 1'b1;
    rnd_data();
    put(5, 8'h5A);
    for (int k = 0; k < N; k++) push(k, 8'h5A, 1'b1, cyc + 1);
    step();
    valid = 1'b0;
    step();
    post("fan_idle", 128'(o_busy), '0);

    // Abort a len-200 burst after 50 samples
    step();
    start[1] = 1'b1;
    set_sel(1, 4'd3);
    len   = 8'd200;
    valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      start = '0;
      valid = 1'b1;
      rnd_data();
      put(3, 8'(i));
      if (i < 49) push(1, 8'(i), 1'b0, cyc + 1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    post("rst_async", outs(), '0);
`ifdef DISTRIBUTOR_OVERRUN_CNT_EN
    post("rst_ovr", 128'(o_overrun), '0);
`endif
    step();
    step();
    rst   = 1'b1;
    valid = 1'b0;
    step();
    post("post_rst", 128'(o_busy), '0);
    step();
    start[1] = 1'b1;
    set_sel(1, 4'd3);
    len = 8'd1;
    step();
    start = '0;
    valid = 1'b1;
    rnd_data();
    put(3, 8'h77);
    push(1, 8'h77, 1'b1, cyc + 1);
    step();
    valid = 1'b0;
    step();
    step();

    for (int k = 0; k < N; k++) begin
      post("sb_empty", 128'(q[k].size()), '0);
    end
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
